// File: rtl/ex_issue_sequencer.sv
// Execute-stage issue sequencer: single-cycle ALU issue, plus a handshaked
// memory read that is aborted with a sticky error after TIMEOUT request cycles.
module ex_issue_sequencer #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [2:0]       instr_opselect,
   input  logic             instr_use_imm,
   output logic             mem_req,
   input  logic             mem_ack,
   input  logic             err_clr,
   output logic             enable_ex,
   output logic [2:0]       opselect,
   output logic             control_in,
   output logic             timeout_err,
   output logic [CNT_W-1:0] issue_count
);

   typedef enum logic {IDLE, MEM_WAIT} state_t;

   localparam logic [2:0] OP_ARITH = 3'b001;
   localparam logic [2:0] OP_MREAD = 3'b101;
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       accept;

   // Ready drops with reset so nothing is accepted while the block is held.
   assign instr_ready = (state == IDLE) && rst_n;
   assign accept      = instr_valid && instr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         mem_req     <= 1'b0;
         enable_ex   <= 1'b0;
         opselect    <= 3'b000;
         control_in  <= 1'b0;
         timeout_err <= 1'b0;
         issue_count <= '0;
      end else begin
         enable_ex <= 1'b0;
         // Clear first so a same-cycle abort below overrides it.
         if (err_clr) timeout_err <= 1'b0;

         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (instr_opselect == OP_ARITH) begin
                     enable_ex   <= 1'b1;
                     opselect    <= OP_ARITH;
                     control_in  <= instr_use_imm;
                     issue_count <= issue_count + CNT_W'(1);
                  end else if (instr_opselect == OP_MREAD) begin
                     mem_req  <= 1'b1;
                     wait_cnt <= 8'd0;
                     state    <= MEM_WAIT;
                  end
               end
            end
            MEM_WAIT: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  enable_ex   <= 1'b1;
                  opselect    <= OP_MREAD;
                  control_in  <= 1'b1;
                  issue_count <= issue_count + CNT_W'(1);
                  state       <= IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  // Abort still strobes execute; control_in=0 tells it to hold.
                  mem_req     <= 1'b0;
                  enable_ex   <= 1'b1;
                  opselect    <= OP_MREAD;
                  control_in  <= 1'b0;
                  timeout_err <= 1'b1;
                  issue_count <= issue_count + CNT_W'(1);
                  state       <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_issue_sequencer.sv
// Directed bench for ex_issue_sequencer: a vector table for the single-cycle
// behaviour plus hand sequences for timeout, ack/timeout race and async reset.
module tb_ex_issue_sequencer;
   localparam int TO = 15;
   localparam int CW = 16;
   localparam logic [2:0] AL = 3'b001;
   localparam logic [2:0] MR = 3'b101;
   localparam logic [2:0] UN = 3'b010;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [2:0]    instr_opselect = 3'b000;
   logic          instr_use_imm = 1'b0;
   logic          mem_req;
   logic          mem_ack = 1'b0;
   logic          err_clr = 1'b0;
   logic          enable_ex;
   logic [2:0]    opselect;
   logic          control_in;
   logic          timeout_err;
   logic [CW-1:0] issue_count;

   ex_issue_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_opselect(instr_opselect), .instr_use_imm(instr_use_imm),
      .mem_req(mem_req), .mem_ack(mem_ack), .err_clr(err_clr),
      .enable_ex(enable_ex), .opselect(opselect), .control_in(control_in),
      .timeout_err(timeout_err), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;

   typedef struct {
      logic       v;
      logic [2:0] op;
      logic       imm, ack, clr;
      logic       rdy, en;
      logic [2:0] eop;
      logic       ctl, req, err;
      int         cnt;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic rdy, input logic en,
                            input logic [2:0] op, input logic ctl, input logic req,
                            input logic err, input int cnt);
      chk({tag, " ready"}, 32'(instr_ready), 32'(rdy));
      chk({tag, " enable_ex"}, 32'(enable_ex), 32'(en));
      chk({tag, " opselect"}, 32'(opselect), 32'(op));
      chk({tag, " control_in"}, 32'(control_in), 32'(ctl));
      chk({tag, " mem_req"}, 32'(mem_req), 32'(req));
      chk({tag, " timeout_err"}, 32'(timeout_err), 32'(err));
      chk({tag, " issue_count"}, 32'(issue_count), 32'(cnt));
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic imm,
                        input logic ack, input logic clr);
      instr_valid = v; instr_opselect = op; instr_use_imm = imm;
      mem_ack = ack; err_clr = clr;
   endtask

   // Accept a MEM_READ and leave the bench sampling the first mem_req cycle.
   task automatic start_read();
      drive(1'b1, MR, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int en_seen;
      int req_seen;

      //           v     op   imm   ack   clr   rdy   en    eop  ctl   req   err   cnt
      tbl[0]  = '{1'b1, AL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, AL, 1'b1, 1'b0, 1'b0, 1};
      tbl[1]  = '{1'b1, AL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, AL, 1'b0, 1'b0, 1'b0, 2};
      tbl[2]  = '{1'b0, AL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, AL, 1'b0, 1'b0, 1'b0, 2};
      tbl[3]  = '{1'b1, MR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AL, 1'b0, 1'b1, 1'b0, 2};
      tbl[4]  = '{1'b0, MR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AL, 1'b0, 1'b1, 1'b0, 2};
      tbl[5]  = '{1'b0, MR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AL, 1'b0, 1'b1, 1'b0, 2};
      tbl[6]  = '{1'b0, MR, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, MR, 1'b1, 1'b0, 1'b0, 3};
      tbl[7]  = '{1'b0, AL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MR, 1'b1, 1'b0, 1'b0, 3};
      tbl[8]  = '{1'b1, UN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MR, 1'b1, 1'b0, 1'b0, 3};
      tbl[9]  = '{1'b1, AL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, AL, 1'b1, 1'b0, 1'b0, 4};
      tbl[10] = '{1'b1, MR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, AL, 1'b1, 1'b1, 1'b0, 4};
      tbl[11] = '{1'b0, AL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, MR, 1'b1, 1'b0, 1'b0, 5};
      tbl[12] = '{1'b1, AL, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, AL, 1'b0, 1'b0, 1'b0, 6};

      // Reset state
      step();
      step();
      check_all("reset", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready after release", 32'(instr_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].op, tbl[i].imm, tbl[i].ack, tbl[i].clr);
         step();
         check_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].en, tbl[i].eop,
                   tbl[i].ctl, tbl[i].req, tbl[i].err, tbl[i].cnt);
      end
      drive(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      exp_cnt = 6;

      // Timeout with no ack: exactly TO request cycles then an abort strobe
      start_read();
      n = 0;
      while (mem_req === 1'b1 && n < 40) begin
         n++;
         chk("timeout ready low", 32'(instr_ready), 32'd0);
         step();
      end
      chk("timeout req cycles", 32'(n), 32'(TO));
      exp_cnt++;
      check_all("abort", 1'b1, 1'b1, MR, 1'b0, 1'b0, 1'b1, exp_cnt);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("err sticky", 32'(timeout_err), 32'd1);
         chk("no extra strobe", 32'(enable_ex), 32'd0);
      end

      // err_clr in the same cycle as a new timeout: set wins
      start_read();
      for (int i = 1; i < TO; i++) step();
      chk("last req cycle", 32'(mem_req), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      exp_cnt++;
      check_all("clr+timeout", 1'b1, 1'b1, MR, 1'b0, 1'b0, 1'b1, exp_cnt);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("err cleared", 32'(timeout_err), 32'd0);

      // Ack on the final request cycle beats the timeout
      start_read();
      for (int i = 1; i < TO; i++) step();
      chk("15th req cycle", 32'(mem_req), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      exp_cnt++;
      check_all("ack at limit", 1'b1, 1'b1, MR, 1'b1, 1'b0, 1'b0, exp_cnt);

      // Unsupported op then reset asserted mid-read
      drive(1'b1, UN, 1'b1, 1'b0, 1'b0);
      step();
      check_all("unsupported", 1'b1, 1'b0, MR, 1'b1, 1'b0, 1'b0, exp_cnt);
      start_read();
      step();
      step();
      chk("mid read req", 32'(mem_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async reset", 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 0);
      step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ready one cycle after release", 32'(instr_ready), 32'd1);
      en_seen = 0;
      req_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (enable_ex === 1'b1) en_seen++;
         if (mem_req === 1'b1) req_seen++;
         step();
      end
      chk("no strobe after reset", 32'(en_seen), 32'd0);
      chk("no req after reset", 32'(req_seen), 32'd0);
      chk("count after reset", 32'(issue_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
